// File: rtl/mult_shift_add.sv
// Sequential 32-bit signed multiplier: one shift-and-add step per multiplier bit,
// low 32 bits of the product plus a signed-overflow flag after 33 cycles.
module mult_shift_add (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  localparam int unsigned W     = 32;
  localparam int unsigned ACC_W = 2 * W;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [W-1:0]       r_mcand;
  logic [W-1:0]       r_mplier;
  logic [ACC_W-1:0]   r_acc;
  logic               r_sign;
  logic [CNT_W-1:0]   r_cnt;

  state_t             w_state_nxt;
  logic [W-1:0]       w_mcand_nxt;
  logic [W-1:0]       w_mplier_nxt;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic               w_sign_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [W-1:0]       w_result_nxt;
  logic               w_exc_nxt;
  logic               w_rdy_nxt;
  logic               w_busy_nxt;

  logic [W-1:0]       w_abs_a;
  logic [W-1:0]       w_abs_b;
  logic [W:0]         w_sum;
  logic [ACC_W-1:0]   w_prod;
  logic               w_prod_fits;

  // Operand magnitudes, partial sum and final signed product
  always_comb begin
    w_abs_a     = data_operandA[W-1] ? W'(-data_operandA) : data_operandA;
    w_abs_b     = data_operandB[W-1] ? W'(-data_operandB) : data_operandB;
    w_sum       = {1'b0, r_acc[ACC_W-1:W]} + (r_mplier[0] ? {1'b0, r_mcand} : (W+1)'(0));
    w_prod      = r_sign ? ACC_W'(-r_acc) : r_acc;
    w_prod_fits = (w_prod[ACC_W-1:W-1] == '0) || (w_prod[ACC_W-1:W-1] == '1);
  end

  // Next-state and output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_acc_nxt    = r_acc;
    w_sign_nxt   = r_sign;
    w_cnt_nxt    = r_cnt;
    w_result_nxt = data_result;
    w_exc_nxt    = data_exception;
    w_rdy_nxt    = 1'b0;
    w_busy_nxt   = ctrl_MULT || (r_state != IDLE);

    case (r_state)
      RUN: begin
        w_acc_nxt    = {w_sum, r_acc[W-1:1]};
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = CNT_W'(r_cnt + CNT_W'(1));
        if (r_cnt == CNT_W'(W - 1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_result_nxt = w_prod[W-1:0];
        w_exc_nxt    = !w_prod_fits || (r_sign && (r_acc > ACC_W'(64'h8000_0000)));
        w_rdy_nxt    = 1'b1;
        w_state_nxt  = IDLE;
      end
      default: begin
      end
    endcase

    // A start wins in every state, aborting any operation in flight
    if (ctrl_MULT) begin
      w_mcand_nxt  = w_abs_a;
      w_mplier_nxt = w_abs_b;
      w_sign_nxt   = (data_operandA[W-1] ^ data_operandB[W-1]) &&
                     (w_abs_a != '0) && (w_abs_b != '0);
      w_acc_nxt    = '0;
      w_cnt_nxt    = '0;
      w_state_nxt  = RUN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_mcand        <= '0;
      r_mplier       <= '0;
      r_acc          <= '0;
      r_sign         <= 1'b0;
      r_cnt          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_mcand        <= w_mcand_nxt;
      r_mplier       <= w_mplier_nxt;
      r_acc          <= w_acc_nxt;
      r_sign         <= w_sign_nxt;
      r_cnt          <= w_cnt_nxt;
      data_result    <= w_result_nxt;
      data_exception <= w_exc_nxt;
      data_resultRDY <= w_rdy_nxt;
      busy           <= w_busy_nxt;
    end
  end

endmodule
